// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and one carry flop.
// Adds a + b + cin LSB first, one bit per clock, using a start/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] ra, rb, ps;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic s, carry_next, accept, last;

   // The single full-adder cell.
   assign s          = ra[0] ^ rb[0] ^ carry;
   assign carry_next = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (cnt == CNT_W'(WIDTH - 1));

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: state_next gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every datapath register is reset, not just the FSM, so an abort
   // returns sum/cout to zero and leaves no stale partial state behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra    <= '0;
         rb    <= '0;
         ps    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         ra    <= a;
         rb    <= b;
         carry <= cin;
         ps    <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         carry <= carry_next;
         ps    <= {s, ps[WIDTH-1:1]};
         ra    <= ra >> 1;
         rb    <= rb >> 1;
         cnt   <= cnt + CNT_W'(1);
         // Outputs update only here, so partial sums are never visible.
         if (last) begin
            sum  <= {s, ps[WIDTH-1:1]};
            cout <= carry_next;
         end
      end
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock through a single full-adder cell and a carry flip-flop. It is the additive counterpart of the team's full-subtractor cell. Subtraction a−b is done by feeding ~b with cin=1, in which case cout=1 means no borrow. It sits between a register-file read port and a result register, using a start/done handshake, where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- cin  input  1  carry-in; sampled on the accepting edge only
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  registered result; held between operations
- cout  output  1  registered carry-out; held between operations

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- **IDLE:**
  - start=1 latches a into shift register ra, b into rb, and cin into the carry flop.
  - The same edge clears the bit counter cnt (width clog2(WIDTH)+1) and the partial-sum register ps, then moves to RUN.
- **RUN, each edge:**
  - s = ra[0]^rb[0]^carry; carry ← majority(ra[0], rb[0], carry).
  - ps ← {s, ps[WIDTH-1:1]}; ra, rb shift right by 1; cnt ← cnt+1.
  - On the edge where cnt==WIDTH-1: load sum ← {s, ps[WIDTH-1:1]} and cout ← new carry, then go to DONE.
- **DONE:** lasts exactly one cycle.
  - start=1 is accepted exactly as in IDLE (go to RUN, load new operands).
  - Otherwise return to IDLE.
- start while in RUN is ignored. The operation is not restarted and operands are not re-sampled.
- a, b and cin may change freely after the accepting edge.
- sum and cout change only on the completing edge. Partial results are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH on sum. cout is bit WIDTH of a+b+cin.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE. Internal ra, rb, ps, carry and cnt are also 0.
- Reset is asynchronous: assertion at any time aborts an operation immediately. No done pulse follows, and outputs return to their reset values.
- Combinational decode of state:
  - busy = (state==RUN).
  - done = (state==DONE).
- **Latency:**
  - start is accepted at edge E0.
  - busy is high from E0 to E_WIDTH.
  - sum/cout are valid and done=1 from edge E_WIDTH until E_WIDTH+1.
  - An operation occupies WIDTH+1 cycles from accept to the end of done.
- **Back-to-back:** start held high continuously gives one result every WIDTH+1 cycles. The DONE cycle accepts the next request, and busy re-asserts on the edge that ends done.
- cnt never wraps: it is reloaded to 0 on every accept.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed 1 cycle → busy high 8 cycles, then done for 1 cycle with sum=0x96, cout=0. busy=0 while done=1.
- **Carry ripple:**
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- **Subtract via complement:**
  - a=0x05, b=~0x07=0xF8, cin=1 → sum=0xFE, cout=0 (borrow).
  - a=0x07, b=0xFA, cin=1 → sum=0x02, cout=1.
- **Ignored start:** start re-pulsed with a=0x11, b=0x22 during cycle 3 of RUN for a=0x01, b=0x02 → a single done at the original time with sum=0x03. sum stays at its previous value until then.
- **Back-to-back:** start held high with a=0x10, b=0x20, changed to a=0x30, b=0x01 during the first DONE cycle → done pulses 9 cycles apart, with sum=0x30 then 0x31.
- **Reset mid-operation:** rst_n low for 1 cycle during RUN cycle 4 → outputs go to 0 immediately and no done pulse follows. The next start with a=0x80, b=0x80 gives sum=0x00, cout=1.
